// File: rtl/synch_fifo_pkg.sv
// Shared defaults and pointer type for the synchronous FIFO controller.
package synch_fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH    = 32;
  localparam int unsigned DEF_ADDR_WIDTH    = 4;
  localparam int unsigned DEF_AFULL_THRESH  = 14;
  localparam int unsigned DEF_AEMPTY_THRESH = 2;
  localparam int unsigned DEPTH             = 2 ** DEF_ADDR_WIDTH;

  // One extra MSB distinguishes full from empty when the low bits match.
  typedef logic [DEF_ADDR_WIDTH:0] ptr_t;

endpackage

// File: rtl/synch_fifo_ctrl_if.sv
// Producer/consumer side of the FIFO: push and pop handshakes plus status flags.
interface synch_fifo_ctrl_if
  import synch_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  pop;
  logic [DATA_WIDTH-1:0] pop_data;
  logic                  pop_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output push, push_data, pop,
    input  pop_data, pop_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  push, push_data, pop,
    output pop_data, pop_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ptr.sv
// Wrapping pointer register with increment enable; used for both FIFO pointers.
module fifo_ptr
  import synch_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_ADDR_WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] ptr_o
);

  logic [WIDTH-1:0] ptr_q;
  logic [WIDTH-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = ptr_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/synch_fifo_ctrl.sv
// Single-clock FIFO controller in front of a 16-entry dual-port sram with registered read data.
module synch_fifo_ctrl
  import synch_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int unsigned AFULL_THRESH  = DEF_AFULL_THRESH,
  parameter int unsigned AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  synch_fifo_ctrl_if.slave      fifo_if,
  output logic                  sram_wren,
  output logic [ADDR_WIDTH-1:0] sram_wrptr,
  output logic [DATA_WIDTH-1:0] sram_wrdata,
  output logic                  sram_rden,
  output logic [ADDR_WIDTH-1:0] sram_rdptr,
  input  logic [DATA_WIDTH-1:0] sram_rddata
);

  localparam logic [ADDR_WIDTH:0] AFULL_LVL  = AFULL_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = AEMPTY_THRESH[ADDR_WIDTH:0];

  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] count;
  logic                full;
  logic                empty;
  logic                push_ok;
  logic                pop_ok;

  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;
  logic pop_valid_q, pop_valid_d;

  fifo_ptr #(.WIDTH(ADDR_WIDTH + 1)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (push_ok),
    .ptr_o (wr_ptr)
  );

  fifo_ptr #(.WIDTH(ADDR_WIDTH + 1)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (pop_ok),
    .ptr_o (rd_ptr)
  );

  // Requests are judged on pre-edge flags, so full+push+pop never hits one address twice.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                   (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
  assign count   = wr_ptr - rd_ptr;
  assign push_ok = fifo_if.push && !full;
  assign pop_ok  = fifo_if.pop && !empty;

  always_comb begin
    overflow_d  = overflow_q | (fifo_if.push && full);
    underflow_d = underflow_q | (fifo_if.pop && empty);
    pop_valid_d = pop_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      pop_valid_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      pop_valid_q <= pop_valid_d;
    end
  end

  assign sram_wren   = push_ok;
  assign sram_wrptr  = wr_ptr[ADDR_WIDTH-1:0];
  assign sram_wrdata = fifo_if.push_data;
  assign sram_rden   = pop_ok;
  assign sram_rdptr  = rd_ptr[ADDR_WIDTH-1:0];

  assign fifo_if.pop_data     = sram_rddata;
  assign fifo_if.pop_valid    = pop_valid_q;
  assign fifo_if.full         = full;
  assign fifo_if.empty        = empty;
  assign fifo_if.almost_full  = (count >= AFULL_LVL);
  assign fifo_if.almost_empty = (count <= AEMPTY_LVL);
  assign fifo_if.count        = count;
  assign fifo_if.overflow     = overflow_q;
  assign fifo_if.underflow    = underflow_q;

endmodule

// File: tb/tb_synch_fifo_ctrl.sv
// Directed bench for synch_fifo_ctrl with an sram model and a data scoreboard.
module tb_synch_fifo_ctrl;
  import synch_fifo_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        sram_wren;
  logic [3:0]  sram_wrptr;
  logic [31:0] sram_wrdata;
  logic        sram_rden;
  logic [3:0]  sram_rdptr;
  logic [31:0] sram_rddata;
  logic [31:0] mem [16];

  int checks = 0;
  int errors = 0;

  ptr_t        wrM, rdM;
  logic        overflowM, underflowM;
  logic [31:0] expQ [$];

  synch_fifo_ctrl_if fifoIf ();

  synch_fifo_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fifo_if     (fifoIf),
    .sram_wren   (sram_wren),
    .sram_wrptr  (sram_wrptr),
    .sram_wrdata (sram_wrdata),
    .sram_rden   (sram_rden),
    .sram_rdptr  (sram_rdptr),
    .sram_rddata (sram_rddata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sram macro: write port plus registered read port
  always @(posedge clk) begin
    if (sram_wren) mem[sram_wrptr] <= sram_wrdata;
    if (sram_rden) sram_rddata <= mem[sram_rdptr];
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkState();
    logic [4:0] mCount;
    mCount = wrM - rdM;
    checkOutput("count", 64'(fifoIf.count), 64'(mCount));
    checkOutput("full", 64'(fifoIf.full), 64'(mCount == 5'd16));
    checkOutput("empty", 64'(fifoIf.empty), 64'(mCount == 5'd0));
    checkOutput("almost_full", 64'(fifoIf.almost_full), 64'(mCount >= 5'd14));
    checkOutput("almost_empty", 64'(fifoIf.almost_empty), 64'(mCount <= 5'd2));
    checkOutput("overflow", 64'(fifoIf.overflow), 64'(overflowM));
    checkOutput("underflow", 64'(fifoIf.underflow), 64'(underflowM));
  endtask

  task automatic resetModel();
    wrM = '0;
    rdM = '0;
    overflowM = 1'b0;
    underflowM = 1'b0;
    expQ.delete();
  endtask

  // One clock cycle: drive, check sram strobes before the edge, check outputs after it.
  task automatic applyStimulus(input logic p, input logic q, input logic [31:0] d);
    logic [4:0]  mCount;
    logic        pushOk, popOk;
    logic [31:0] expData;
    fifoIf.push = p;
    fifoIf.pop = q;
    fifoIf.push_data = d;
    mCount = wrM - rdM;
    pushOk = p && (mCount != 5'd16);
    popOk = q && (mCount != 5'd0);
    expData = '0;
    #1;
    checkOutput("sram_wren", 64'(sram_wren), 64'(pushOk));
    checkOutput("sram_rden", 64'(sram_rden), 64'(popOk));
    if (pushOk) begin
      checkOutput("sram_wrptr", 64'(sram_wrptr), 64'(wrM[3:0]));
      checkOutput("sram_wrdata", 64'(sram_wrdata), 64'(d));
    end
    if (popOk) checkOutput("sram_rdptr", 64'(sram_rdptr), 64'(rdM[3:0]));
    @(posedge clk);
    if (p && !pushOk) overflowM = 1'b1;
    if (q && !popOk) underflowM = 1'b1;
    if (pushOk) begin
      expQ.push_back(d);
      wrM = wrM + 1'b1;
    end
    if (popOk) begin
      expData = expQ.pop_front();
      rdM = rdM + 1'b1;
    end
    #1;
    fifoIf.push = 1'b0;
    fifoIf.pop = 1'b0;
    checkOutput("pop_valid", 64'(fifoIf.pop_valid), 64'(popOk));
    if (popOk) checkOutput("pop_data", 64'(fifoIf.pop_data), 64'(expData));
    checkState();
  endtask

  initial begin
    rst_n = 1'b0;
    fifoIf.push = 1'b0;
    fifoIf.pop = 1'b0;
    fifoIf.push_data = '0;
    resetModel();
    #1;
    checkOutput("rst_empty", 64'(fifoIf.empty), 64'd1);
    checkOutput("rst_count", 64'(fifoIf.count), 64'd0);
    checkOutput("rst_full", 64'(fifoIf.full), 64'd0);
    checkOutput("rst_wren", 64'(sram_wren), 64'd0);
    checkOutput("rst_rden", 64'(sram_rden), 64'd0);
    checkOutput("rst_pop_valid", 64'(fifoIf.pop_valid), 64'd0);
    checkOutput("rst_almost_empty", 64'(fifoIf.almost_empty), 64'd1);
    checkOutput("rst_almost_full", 64'(fifoIf.almost_full), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    $display("[TB] idle after reset");
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);

    $display("[TB] fill to full, then overflow");
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 32'h11 + 32'(i));
    applyStimulus(1'b1, 1'b0, 32'hDEAD);

    $display("[TB] drain, then underflow");
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0);

    $display("[TB] streaming push+pop at count 3");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h50 + 32'(i));
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b1, 32'h100 + 32'(i));

    $display("[TB] push+pop while full");
    for (int i = 0; i < 13; i++) applyStimulus(1'b1, 1'b0, 32'h200 + 32'(i));
    applyStimulus(1'b1, 1'b1, 32'hBAD0);

    $display("[TB] push+pop while empty");
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b1, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h300);

    $display("[TB] reset mid-stream at count 7");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'h400 + 32'(i));
    applyStimulus(1'b1, 1'b1, 32'h406);
    #2;
    rst_n = 1'b0;
    #1;
    resetModel();
    checkOutput("midrst_pop_valid", 64'(fifoIf.pop_valid), 64'd0);
    checkState();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 32'hAB);
    applyStimulus(1'b0, 1'b1, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
